// File: rtl/mul_iter_pkg.sv
// Shared encodings and operand-sign helpers for the iterative RV32M multiplier.
package mul_iter_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  // rs1 is signed for every op except MULHU; rs2 only for MUL and MULH.
  function automatic logic op_x_signed(input mul_op_e op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_y_signed(input mul_op_e op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/result handshake bundle between a requester and the iterative multiplier.
interface mul_iter_if
  import mul_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) ();

  logic             in_valid;
  logic             out_ready;
  mul_op_e          in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             in_result_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_busy;

  modport master (
    output in_valid, in_op, in_x, in_y, in_result_ready,
    input  out_ready, out_valid, out_result, out_busy
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_result_ready,
    output out_ready, out_valid, out_result, out_busy
  );

endinterface

// File: rtl/mul_iter_adder.sv
// Combinational adder with carry-out and a signed/unsigned overflow flag.
module mul_iter_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

  generate
    if (SIGNED) begin : g_signed
      assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin : g_unsigned
      assign overflow = carry;
    end
  endgenerate

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU: sign-magnitude
// operands, WIDTH add-and-shift cycles, then a single 2*WIDTH sign fix-up.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic       in_clk,
  input  logic       in_rst,
  mul_iter_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  mul_state_e       state_q, state_d;
  mul_op_e          op_q, op_d;
  logic [WIDTH-1:0] mag_x_q, mag_x_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             sx, sy;
  logic [WIDTH-1:0] addend, sum;
  logic             carry;
  logic             adder_ovf_unused;
  logic [PW-1:0]    prod, prod_fix;

  assign addend = lo_q[0] ? mag_x_q : '0;

  mul_iter_adder #(
    .WIDTH  (WIDTH),
    .SIGNED (1'b0)
  ) u_adder (
    .a        (hi_q),
    .b        (addend),
    .sum      (sum),
    .carry    (carry),
    .overflow (adder_ovf_unused)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_x_d  = mag_x_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    count_d  = count_q;
    neg_d    = neg_q;
    valid_d  = valid_q;

    sx       = bus.in_x[WIDTH-1] & op_x_signed(bus.in_op);
    sy       = bus.in_y[WIDTH-1] & op_y_signed(bus.in_op);
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? (~prod + PW'(1)) : prod;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && ready_q) begin
          op_d    = bus.in_op;
          mag_x_d = sx ? (~bus.in_x + WIDTH'(1)) : bus.in_x;
          lo_d    = sy ? (~bus.in_y + WIDTH'(1)) : bus.in_y;
          hi_d    = '0;
          neg_d   = sx ^ sy;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Carry-out of the add becomes the new MSB as the pair shifts right.
        {hi_d, lo_d} = {carry, sum, lo_q[WIDTH-1:1]};
        count_d      = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = (op_q == MUL_OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.in_result_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MUL_OP_MUL;
      mag_x_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_x_q  <= mag_x_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.out_ready  = ready_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_busy   = busy_q;

endmodule

// File: tb/tb_mul_iter.sv
// Directed-vector bench for mul_iter: latency, signed/unsigned products, backpressure, reset abort.
module tb_mul_iter;
  import mul_iter_pkg::*;

  localparam int unsigned W = 32;

  logic in_clk = 1'b0;
  logic in_rst;
  int   vectors     = 0;
  int   miscompares = 0;

  mul_iter_if #(.WIDTH(W)) bus ();

  mul_iter #(.WIDTH(W)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  // Presents an op for one edge (must be called while idle), then scrambles operands.
  task automatic accept(input mul_op_e op, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_x     = $urandom();
    bus.in_y     = $urandom();
    bus.in_op    = MUL_OP_MULHU;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic consume();
    bus.in_result_ready = 1'b1;
    step();
    bus.in_result_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    repeat (3) step();
    in_rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b result=%h, expected valid=0 result=00000000",
               bus.out_valid, bus.out_result);
    end
    vectors++;
    if (bus.out_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: ready=%b busy=%b, expected ready=1 busy=0", bus.out_ready, bus.out_busy);
    end
  endtask

  task automatic test_mul_small();
    int cyc;
    accept(MUL_OP_MUL, 32'd6, 32'd7);
    vectors++;
    if (bus.out_ready !== 1'b0 || bus.out_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL calc_flags: ready=%b busy=%b, expected ready=0 busy=1", bus.out_ready, bus.out_busy);
    end
    wait_valid(cyc);
    vectors++;
    if (cyc != 33) begin
      miscompares++;
      $display("FAIL latency_mul_6x7: got %0d cycles, expected 33", cyc);
    end
    vectors++;
    if (bus.out_result !== 32'h0000_002A) begin
      miscompares++;
      $display("FAIL mul_6x7: got %h, expected 0000002a", bus.out_result);
    end
    consume();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL consume_6x7: valid=%b ready=%b, expected valid=0 ready=1", bus.out_valid, bus.out_ready);
    end
  endtask

  task automatic test_table(input string grp, input mul_op_e ops[7], input logic [W-1:0] xs[7],
                            input logic [W-1:0] ys[7], input logic [W-1:0] exps[7]);
    int cyc;
    for (int i = 0; i < 7; i++) begin
      accept(ops[i], xs[i], ys[i]);
      wait_valid(cyc);
      vectors++;
      if (cyc != 33 || bus.out_result !== exps[i]) begin
        miscompares++;
        $display("FAIL %s[%0d] op=%0d x=%h y=%h: got %h after %0d cycles, expected %h after 33",
                 grp, i, ops[i], xs[i], ys[i], bus.out_result, cyc, exps[i]);
      end
      consume();
    end
  endtask

  task automatic test_signed();
    mul_op_e          ops[7];
    logic [W-1:0]     xs[7], ys[7], exps[7];
    ops  = '{MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULH, MUL_OP_MUL, MUL_OP_MULHU, MUL_OP_MULH, MUL_OP_MUL};
    xs   = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ys   = '{32'd5, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 32'h0000_0004,
             32'h0000_0000, 32'h0000_0001};
    test_table("signed", ops, xs, ys, exps);
  endtask

  task automatic test_boundary();
    mul_op_e          ops[7];
    logic [W-1:0]     xs[7], ys[7], exps[7];
    ops  = '{MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU, MUL_OP_MULHSU, MUL_OP_MULHSU, MUL_OP_MUL, MUL_OP_MULHU};
    xs   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'h0};
    ys   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
             32'hFFFF_FFFF};
    exps = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 32'h0};
    test_table("boundary", ops, xs, ys, exps);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bad;
    accept(MUL_OP_MUL, 32'h1234, 32'h10);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = MUL_OP_MUL;
      bus.in_x     = 32'hFFFF;
      bus.in_y     = 32'hFFFF;
      step();
      if (bus.out_ready !== 1'b0 || bus.out_busy !== 1'b1) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL calc_ignore_valid: ready/busy wrong during CALC, expected ready=0 busy=1");
    end
    wait_valid(cyc);
    vectors++;
    if (cyc != 28 || bus.out_result !== 32'h0001_2340) begin
      miscompares++;
      $display("FAIL bp_result: got %h after %0d more cycles, expected 00012340 after 28", bus.out_result, cyc);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      step();
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0001_2340 || bus.out_ready !== 1'b0) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b result=%h ready=%b, expected 1/00012340/0 stable for 10 cycles",
               bus.out_valid, bus.out_result, bus.out_ready);
    end
    consume();
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b ready=%b busy=%b, expected 0/1/0",
               bus.out_valid, bus.out_ready, bus.out_busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    accept(MUL_OP_MUL, 32'hFFFF, 32'hFFFF);
    repeat (15) step();
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    vectors++;
    if (bus.out_ready !== 1'b1 || bus.out_busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: ready=%b busy=%b valid=%b, expected 1/0/0",
               bus.out_ready, bus.out_busy, bus.out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_mid_no_valid: out_valid raised for abandoned op, expected stay 0");
    end
    accept(MUL_OP_MUL, 32'h0, 32'h1234);
    wait_valid(cyc);
    vectors++;
    if (cyc != 33 || bus.out_result !== 32'h0) begin
      miscompares++;
      $display("FAIL after_reset_mul0: got %h after %0d cycles, expected 00000000 after 33", bus.out_result, cyc);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.in_op           = MUL_OP_MULHU;
    bus.in_x            = 32'h0001_0000;
    bus.in_y            = 32'h0001_0000;
    bus.in_valid        = 1'b1;
    bus.in_result_ready = 1'b1;
    step();
    bus.in_op = MUL_OP_MUL;
    bus.in_x  = 32'hFFFF_FFFF;
    bus.in_y  = 32'd3;
    wait_valid(cyc);
    vectors++;
    if (cyc != 33 || bus.out_result !== 32'h1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h after %0d cycles, expected 00000001 after 33", bus.out_result, cyc);
    end
    step();
    vectors++;
    if (bus.out_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: ready=%b valid=%b, expected ready=1 valid=0", bus.out_ready, bus.out_valid);
    end
    wait_valid(cyc);
    bus.in_valid = 1'b0;
    vectors++;
    if (cyc != 34 || bus.out_result !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL b2b_second: got %h after %0d cycles, expected fffffffd after 34", bus.out_result, cyc);
    end
    step();
    bus.in_result_ready = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: valid=%b ready=%b busy=%b, expected 0/1/0",
               bus.out_valid, bus.out_ready, bus.out_busy);
    end
  endtask

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_op           = MUL_OP_MUL;
    bus.in_x            = '0;
    bus.in_y            = '0;
    bus.in_result_ready = 1'b0;
    in_rst              = 1'b1;
    test_reset();
    test_mul_small();
    test_signed();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
